// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: NUM_CH servo PWM outputs sharing one frame counter, with clamped
// targets. Define SERVO_SLEW_EN to limit the per-frame change of each active width to STEP.
module servo_pwm_bank #(
  parameter int NUM_CH        = 4,
  parameter int PERIOD_CYCLES = 1_000_000,
  parameter int MIN_PULSE     = 50_000,
  parameter int MAX_PULSE     = 100_000,
  parameter int RESET_PULSE   = 50_000,
  parameter int STEP          = 2_500,
  parameter int PW_W          = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [3:0]        cmd_ch_i,
  input  logic [PW_W-1:0]   cmd_pulse_i,
  output logic              cmd_err_o,
  output logic [NUM_CH-1:0] servo_out_o,
  output logic [NUM_CH-1:0] busy_o,
  output logic              frame_tick_o
);
  localparam int PW1 = PW_W + 1;
  localparam logic [PW_W-1:0] LAST_CNT = PW_W'(PERIOD_CYCLES - 1);
  localparam logic [PW_W-1:0] MIN_P    = PW_W'(MIN_PULSE);
  localparam logic [PW_W-1:0] MAX_P    = PW_W'(MAX_PULSE);
  localparam logic [PW_W-1:0] RST_P    = PW_W'(RESET_PULSE);
  localparam logic [PW1-1:0]  STEP_X   = PW1'(STEP);

  if (STEP < 1 || RESET_PULSE < MIN_PULSE || RESET_PULSE > MAX_PULSE ||
      NUM_CH < 1 || NUM_CH > 16 || (64'd1 << PW_W) <= 64'(PERIOD_CYCLES)) begin : g_bad_cfg
    $error("servo_pwm_bank: illegal parameter combination");
  end

  logic [PW_W-1:0]   cnt_q, cnt_d;
  logic [PW_W-1:0]   target_q [NUM_CH];
  logic [PW_W-1:0]   target_d [NUM_CH];
  logic [PW_W-1:0]   active_q [NUM_CH];
  logic [PW_W-1:0]   active_d [NUM_CH];
  logic [NUM_CH-1:0] servo_q, servo_d;
  logic              frame_tick_q, cmd_err_q, first_q;
  logic              update, cmd_acc, ch_ok;
  logic [PW_W-1:0]   pulse_clamped;

  // Handshake: a command transfers on any rising clk edge where cmd_valid_i and
  // cmd_ready_o are both high; ready drops only in the slew-update cycle.
  assign update       = (cnt_q == LAST_CNT);
  assign cmd_ready_o  = !update;
  assign cmd_acc      = cmd_valid_i && cmd_ready_o;
  assign ch_ok        = ({1'b0, cmd_ch_i} < 5'(NUM_CH));
  assign cmd_err_o    = cmd_err_q;
  assign servo_out_o  = servo_q;
  assign frame_tick_o = frame_tick_q;

  always_comb begin
    pulse_clamped = cmd_pulse_i;
    if (cmd_pulse_i < MIN_P)      pulse_clamped = MIN_P;
    else if (cmd_pulse_i > MAX_P) pulse_clamped = MAX_P;
  end

  always_comb begin
    cnt_d = update ? '0 : cnt_q + PW_W'(1);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      target_d[ch] = target_q[ch];
      active_d[ch] = active_q[ch];
      servo_d[ch]  = (cnt_q < active_q[ch]);
      busy_o[ch]   = (active_q[ch] != target_q[ch]);
      if (cmd_acc && ch_ok && (cmd_ch_i == 4'(ch))) target_d[ch] = pulse_clamped;
      if (update) begin
`ifdef SERVO_SLEW_EN
        // Widened compares keep active +/- STEP from wrapping near the range ends.
        if (({1'b0, active_q[ch]} + STEP_X) < {1'b0, target_q[ch]})
          active_d[ch] = PW_W'({1'b0, active_q[ch]} + STEP_X);
        else if (active_q[ch] < target_q[ch])
          active_d[ch] = target_q[ch];
        else if ({1'b0, active_q[ch]} > ({1'b0, target_q[ch]} + STEP_X))
          active_d[ch] = PW_W'({1'b0, active_q[ch]} - STEP_X);
        else
          active_d[ch] = target_q[ch];
`else
        active_d[ch] = target_q[ch];
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      servo_q      <= '0;
      frame_tick_q <= 1'b0;
      cmd_err_q    <= 1'b0;
      first_q      <= 1'b1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        target_q[ch] <= RST_P;
        active_q[ch] <= RST_P;
      end
    end else begin
      cnt_q        <= cnt_d;
      servo_q      <= servo_d;
      // The frame that starts straight out of reset carries no tick.
      frame_tick_q <= (cnt_q == '0) && !first_q;
      first_q      <= 1'b0;
      cmd_err_q    <= cmd_acc && !ch_ok;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        target_q[ch] <= target_d[ch];
        active_q[ch] <= active_d[ch];
      end
    end
  end
endmodule

// File: tb/tb_servo_pwm_bank.sv
// Testbench for servo_pwm_bank: directed vector table plus hand-written frame sequences,
// with expectations adjusted for SERVO_SLEW_EN.
module tb_servo_pwm_bank;
  localparam int NUM_CH = 4, PERIOD = 1000, MIN_P = 50, MAX_P = 100;
  localparam int RST_P = 50, STEP = 10, PW_W = 20, BOUND = 3000;

  logic              clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [3:0]        cmd_ch = '0;
  logic [PW_W-1:0]   cmd_pulse = '0;
  logic              cmd_ready, cmd_err, frame_tick;
  logic [NUM_CH-1:0] servo_out, busy;

  int checks = 0, errors = 0;
  int pos = 0;
  int exp_act[NUM_CH];
  logic [PW_W-1:0] exp_q[$];

  typedef struct { int ch; int pulse; int tgt; int nfr; } vec_t;
  vec_t vecs[5];

  servo_pwm_bank #(
    .NUM_CH(NUM_CH), .PERIOD_CYCLES(PERIOD), .MIN_PULSE(MIN_P), .MAX_PULSE(MAX_P),
    .RESET_PULSE(RST_P), .STEP(STEP), .PW_W(PW_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_ch_i(cmd_ch), .cmd_pulse_i(cmd_pulse), .cmd_err_o(cmd_err),
    .servo_out_o(servo_out), .busy_o(busy), .frame_tick_o(frame_tick)
  );

  // clock / reset and frame position reference
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst) pos <= 0;
    else     pos <= (pos == PERIOD - 1) ? 0 : pos + 1;
  end

  initial begin
    #1_500_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic int next_act(input int a, input int t);
`ifdef SERVO_SLEW_EN
    if (a < t) return (a + STEP < t) ? a + STEP : t;
    if (a > t) return (a - STEP > t) ? a - STEP : t;
    return a;
`else
    return (a == t) ? a : t;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no event within %0d cycles", name, BOUND);
  endtask

  // driver tasks; all are entered and left on a falling edge
  task automatic wait_pos(input int p);
    int n = 0;
    @(negedge clk);
    while (pos != p) begin
      @(negedge clk);
      if (++n > BOUND) begin timeout("wait_pos"); return; end
    end
  endtask

  task automatic send(input int ch, input int pulse);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_ch    = 4'(ch);
    cmd_pulse = PW_W'(pulse);
    while (!cmd_ready) begin
      @(negedge clk);
      if (++n > BOUND) begin timeout("send ready"); cmd_valid = 1'b0; return; end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic measure(input int ch, output int w);
    int n = 0;
    w = -1;
    while (servo_out[ch]) begin
      @(negedge clk);
      if (++n > BOUND) begin timeout("measure fall"); return; end
    end
    n = 0;
    while (!servo_out[ch]) begin
      @(negedge clk);
      if (++n > BOUND) begin timeout("measure rise"); return; end
    end
    w = 0;
    while (servo_out[ch]) begin
      w++;
      @(negedge clk);
      if (w > BOUND) begin timeout("measure width"); return; end
    end
  endtask

  task automatic measure_all(input string tag);
    int w0, w1, w2, w3;
    fork
      measure(0, w0);
      measure(1, w1);
      measure(2, w2);
      measure(3, w3);
    join
    check({tag, " width ch0"}, w0, exp_act[0]);
    check({tag, " width ch1"}, w1, exp_act[1]);
    check({tag, " width ch2"}, w2, exp_act[2]);
    check({tag, " width ch3"}, w3, exp_act[3]);
  endtask

  initial begin
    int w, wg, wg1, a;
    vecs[0] = '{1, 100, 100, 5};
    vecs[1] = '{2, 10,  50,  1};
    vecs[2] = '{2, 500, 100, 5};
    vecs[3] = '{2, 10,  50,  5};
    vecs[4] = '{3, 75,  75,  3};
    for (int i = 0; i < NUM_CH; i++) exp_act[i] = RST_P;

    // reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst servo_out", servo_out, 0);
    check("rst busy", busy, 0);
    check("rst frame_tick", frame_tick, 0);
    check("rst cmd_err", cmd_err, 0);
    check("rst cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    check("release servo_out 2nd cycle", servo_out, 15);
    check("first frame tick suppressed", frame_tick, 0);
    wait_pos(999);
    check("ready update cycle", cmd_ready, 0);
    check("tick at cnt 999", frame_tick, 0);
    @(negedge clk);
    check("ready cnt 0", cmd_ready, 1);
    @(negedge clk);
    check("frame_tick new frame", frame_tick, 1);
    @(negedge clk);
    check("frame_tick one cycle", frame_tick, 0);
    measure_all("reset");
    check("reset busy", busy, 0);

    // table-driven writes: slew up, clamp low/high, slew down, mid value
    for (int i = 0; i < 5; i++) begin
      wait_pos(200);
      send(vecs[i].ch, vecs[i].pulse);
      a = exp_act[vecs[i].ch];
      check("busy after write", busy[vecs[i].ch], int'(a != vecs[i].tgt));
      check("no cmd_err on good ch", cmd_err, 0);
      for (int f = 0; f < vecs[i].nfr; f++) begin
        a = next_act(a, vecs[i].tgt);
        exp_q.push_back(PW_W'(a));
        measure(vecs[i].ch, w);
        check("vector width", w, int'(exp_q.pop_front()));
        check("vector busy", busy[vecs[i].ch], int'(a != vecs[i].tgt));
      end
      exp_act[vecs[i].ch] = a;
    end

    // bad channel
    wait_pos(300);
    check("cmd_err before bad", cmd_err, 0);
    send(7, 80);
    check("cmd_err pulse", cmd_err, 1);
    @(negedge clk);
    check("cmd_err one cycle", cmd_err, 0);
    measure_all("bad ch");
    check("bad ch busy", busy, 0);

    // command held across the update cycle
    a = exp_act[3];
    wait_pos(999);
    check("stall ready 999", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd_ch    = 4'd3;
    cmd_pulse = PW_W'(95);
    fork
      begin
        @(negedge clk);
        check("stall ready cnt 0", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
      end
      begin
        measure(3, wg);
        measure(3, wg1);
      end
    join
    check("stall frame unchanged", wg, a);
    a = next_act(a, 95);
    check("stall frame after", wg1, a);
    for (int f = 0; f < 4 && a != 95; f++) begin
      a = next_act(a, 95);
      measure(3, w);
      check("stall settle width", w, a);
    end
    check("stall busy", busy[3], 0);
    exp_act[3] = a;

    // mid-slew reversal on ch0
    a = exp_act[0];
    wait_pos(200);
    send(0, 100);
    for (int f = 0; f < 2; f++) begin
      a = next_act(a, 100);
      measure(0, w);
      check("reversal up width", w, a);
    end
    wait_pos(200);
    send(0, 50);
    for (int f = 0; f < 2; f++) begin
      a = next_act(a, 50);
      measure(0, w);
      check("reversal down width", w, a);
    end
    check("reversal busy", busy[0], 0);

    // reset in the middle of a pulse, with a slew pending on ch2
    wait_pos(200);
    send(2, 100);
    measure(2, w);
    check("pre-reset ch2 width", w, next_act(50, 100));
    wait_pos(30);
    check("mid pulse high", servo_out, 15);
    rst = 1'b1;
    @(negedge clk);
    check("mid reset servo_out", servo_out, 0);
    check("mid reset busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NUM_CH; i++) exp_act[i] = RST_P;
    measure_all("post reset");
    measure(2, w);
    check("post reset ch2 target lost", w, RST_P);
    check("post reset busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
